decode_unit: RTL and testbench

Second pipeline stage of the in-order RV32I core. It sits directly downstream of the fetch stage and consumes its registered `instr`, `pc` and `pc_next`. It decodes the instruction, reads the internal 32×32 register file (with same-cycle writeback bypass) and generates the sign-extended immediate and control bits. It detects load-use hazards and registers everything into the decode/execute pipeline register consumed by the execute stage.

---
 rtl/decode_unit.sv | 194 +++++++++++++++++++
 tb/tb_decode_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// RV32I decode stage: field split, immediates, control, regfile read with writeback bypass.
// Latency: 1 cycle into the ex_* pipeline register; stall_req is combinational.
// Backpressure: stall_req raises on load-use so fetch holds; stage_ena=0 freezes ex_*.
module decode_unit (
    input  logic        stage_clk,
    input  logic        reset,
    input  logic        stage_ena,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_req,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_next,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic [6:0]  ex_opcode,
    output logic        ex_reg_we,
    output logic        ex_mem_re,
    output logic        ex_mem_we,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_alu_src_imm,
    output logic        ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        alu_src_imm;
        logic        illegal;
    } dx_t;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] rf [32];
    logic        uses_rs1, uses_rs2;
    dx_t         dx_d, dx_q;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Writeback in the same cycle wins over the array so the consumer needs no extra stall.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                      (wb_we && wb_rd == rs1) ? wb_data : rf[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                      (wb_we && wb_rd == rs2) ? wb_data : rf[rs2];

    always_comb begin
        dx_d          = '0;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b0;
        dx_d.valid    = 1'b1;
        dx_d.pc       = pc;
        dx_d.pc_next  = pc_next;
        dx_d.rs1_data = rs1_data;
        dx_d.rs2_data = rs2_data;
        dx_d.rd       = rd;
        dx_d.funct3   = instr[14:12];
        dx_d.funct7b5 = instr[30];
        dx_d.opcode   = opcode;
        case (opcode)
            OP_R: begin
                dx_d.reg_we = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_IMM: begin
                dx_d.reg_we      = 1'b1;
                dx_d.alu_src_imm = 1'b1;
                dx_d.imm         = imm_i;
            end
            OP_LOAD: begin
                dx_d.reg_we      = 1'b1;
                dx_d.mem_re      = 1'b1;
                dx_d.alu_src_imm = 1'b1;
                dx_d.imm         = imm_i;
            end
            OP_STORE: begin
                dx_d.mem_we      = 1'b1;
                dx_d.alu_src_imm = 1'b1;
                dx_d.imm         = imm_s;
                uses_rs2         = 1'b1;
            end
            OP_BRANCH: begin
                dx_d.branch = 1'b1;
                dx_d.imm    = imm_b;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                dx_d.reg_we = 1'b1;
                dx_d.jump   = 1'b1;
                dx_d.imm    = imm_j;
                uses_rs1    = 1'b0;
            end
            OP_JALR: begin
                dx_d.reg_we      = 1'b1;
                dx_d.jump        = 1'b1;
                dx_d.alu_src_imm = 1'b1;
                dx_d.imm         = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                dx_d.reg_we      = 1'b1;
                dx_d.alu_src_imm = 1'b1;
                dx_d.imm         = imm_u;
                uses_rs1         = 1'b0;
            end
            default: dx_d.illegal = 1'b1;
        endcase
        if (rd == 5'd0) dx_d.reg_we = 1'b0;
        // All-zero word is the fetch reset value, not an illegal instruction.
        if (instr == 32'd0) dx_d = '0;
    end

    assign stall_req = dx_q.valid && dx_q.mem_re && (dx_q.rd != 5'd0) &&
                       ((uses_rs1 && rs1 == dx_q.rd) || (uses_rs2 && rs2 == dx_q.rd));

    always_ff @(posedge stage_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge stage_clk or negedge reset) begin
        if (!reset) begin
            dx_q <= '0;
        end else if (flush) begin
            dx_q <= '0;
        end else if (stage_ena) begin
            dx_q <= stall_req ? '0 : dx_d;
        end
    end

    assign ex_valid       = dx_q.valid;
    assign ex_pc          = dx_q.pc;
    assign ex_pc_next     = dx_q.pc_next;
    assign ex_rs1_data    = dx_q.rs1_data;
    assign ex_rs2_data    = dx_q.rs2_data;
    assign ex_imm         = dx_q.imm;
    assign ex_rd          = dx_q.rd;
    assign ex_funct3      = dx_q.funct3;
    assign ex_funct7b5    = dx_q.funct7b5;
    assign ex_opcode      = dx_q.opcode;
    assign ex_reg_we      = dx_q.reg_we;
    assign ex_mem_re      = dx_q.mem_re;
    assign ex_mem_we      = dx_q.mem_we;
    assign ex_branch      = dx_q.branch;
    assign ex_jump        = dx_q.jump;
    assign ex_alu_src_imm = dx_q.alu_src_imm;
    assign ex_illegal     = dx_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Random and directed stimulus for decode_unit against an instruction-level model.
module tb_decode_unit;

    logic        stage_clk = 1'b0;
    logic        reset = 1'b0;
    logic        stage_ena = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] pc_next = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall_req, ex_valid;
    logic [31:0] ex_pc, ex_pc_next, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [6:0]  ex_opcode;
    logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal;

    decode_unit dut (
        .stage_clk(stage_clk), .reset(reset), .stage_ena(stage_ena), .flush(flush),
        .instr(instr), .pc(pc), .pc_next(pc_next),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_req(stall_req), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_next(ex_pc_next),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_opcode(ex_opcode),
        .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm),
        .ex_illegal(ex_illegal)
    );

    always #5 stage_clk = ~stage_clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, pcn, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [6:0]  op;
        logic        reg_we, mem_re, mem_we, branch, jump, alu_imm, illegal;
    } ex_t;

    int          n_checks = 0;
    int          n_fail = 0;
    ex_t         m_ex = '0;
    logic [31:0] m_rf [32];
    logic        obs_stall;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    // Instruction-level meaning of each opcode, with immediates built by shifts and masks.
    function automatic ex_t m_decode(input logic [31:0] i, input logic [31:0] p, input logic [31:0] pn);
        ex_t         e;
        logic [31:0] hi;
        logic [6:0]  ctl;  // reg_we mem_re mem_we branch jump alu_imm illegal
        logic [31:0] im;
        hi = i[31] ? 32'hFFFF_FFFF : 32'd0;
        im = 32'd0;
        case (i[6:0])
            7'h33: ctl = 7'b1000000;
            7'h13: begin ctl = 7'b1000010; im = (hi << 12) | (i >> 20); end
            7'h03: begin ctl = 7'b1100010; im = (hi << 12) | (i >> 20); end
            7'h23: begin ctl = 7'b0010010; im = (hi << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F); end
            7'h63: begin ctl = 7'b0001000;
                   im = (hi << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1); end
            7'h6F: begin ctl = 7'b1000100;
                   im = (hi << 20) | (i & 32'h000F_F000) | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1); end
            7'h67: begin ctl = 7'b1000110; im = (hi << 12) | (i >> 20); end
            7'h37, 7'h17: begin ctl = 7'b1000010; im = i & 32'hFFFF_F000; end
            default: ctl = 7'b0000001;
        endcase
        e = '0;
        if (i == 32'd0) return e;
        e.valid = 1'b1;
        e.pc = p;
        e.pcn = pn;
        e.rs1 = m_read(i[19:15]);
        e.rs2 = m_read(i[24:20]);
        e.imm = im;
        e.rd = i[11:7];
        e.f3 = i[14:12];
        e.f7 = i[30];
        e.op = i[6:0];
        {e.reg_we, e.mem_re, e.mem_we, e.branch, e.jump, e.alu_imm, e.illegal} = ctl;
        if (e.rd == 0) e.reg_we = 1'b0;
        return e;
    endfunction

    function automatic logic m_stall(input logic [31:0] i);
        logic u1, u2;
        u1 = !(i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F);
        u2 = (i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63);
        return m_ex.valid && m_ex.mem_re && m_ex.rd != 0 &&
               ((u1 && i[19:15] == m_ex.rd) || (u2 && i[24:20] == m_ex.rd));
    endfunction

    task automatic cmp_ex(input string tag);
        chk_val({tag, ".valid"},   32'(ex_valid),       32'(m_ex.valid));
        chk_val({tag, ".pc"},      ex_pc,               m_ex.pc);
        chk_val({tag, ".pc_next"}, ex_pc_next,          m_ex.pcn);
        chk_val({tag, ".rs1"},     ex_rs1_data,         m_ex.rs1);
        chk_val({tag, ".rs2"},     ex_rs2_data,         m_ex.rs2);
        chk_val({tag, ".imm"},     ex_imm,              m_ex.imm);
        chk_val({tag, ".rd"},      32'(ex_rd),          32'(m_ex.rd));
        chk_val({tag, ".funct3"},  32'(ex_funct3),      32'(m_ex.f3));
        chk_val({tag, ".f7b5"},    32'(ex_funct7b5),    32'(m_ex.f7));
        chk_val({tag, ".opcode"},  32'(ex_opcode),      32'(m_ex.op));
        chk_val({tag, ".ctl"},
                32'({ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal}),
                32'({m_ex.reg_we, m_ex.mem_re, m_ex.mem_we, m_ex.branch, m_ex.jump, m_ex.alu_imm, m_ex.illegal}));
    endtask

    task automatic step(input logic [31:0] i, input logic en, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        ex_t nxt;
        logic st;
        @(negedge stage_clk);
        instr = i; stage_ena = en; flush = fl;
        pc = $urandom & 32'hFFFF_FFFC; pc_next = pc + 32'd4;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        st = m_stall(i);
        obs_stall = stall_req;
        chk_val("stall_req", 32'(stall_req), 32'(st));
        nxt = m_decode(i, pc, pc_next);
        @(posedge stage_clk);
        if (fl) m_ex = '0;
        else if (en && st) m_ex = '0;
        else if (en) m_ex = nxt;
        if (we && wrd != 0) m_rf[wrd] = wd;
        #1;
        cmp_ex("ex");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int k;
        k = $urandom_range(0, 11);
        i = $urandom;
        case (k)
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2, 9: i[6:0] = 7'h03;
            3: i[6:0] = 7'h23;
            4: i[6:0] = 7'h63;
            5: i[6:0] = 7'h6F;
            6: i[6:0] = 7'h67;
            7: i[6:0] = 7'h37;
            8: i[6:0] = 7'h17;
            10: i = 32'd0;
            default: i[6:0] = (i[31]) ? 7'h7F : 7'h0B;
        endcase
        if (k != 10) begin
            i[11:7]  = 5'($urandom_range(0, 7));
            i[19:15] = 5'($urandom_range(0, 7));
            i[24:20] = 5'($urandom_range(0, 7));
        end
        return i;
    endfunction

    task automatic rand_run(input int n);
        for (int c = 0; c < n; c++) begin
            step(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                 $urandom);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;

        // Reset held with live inputs: nothing may load and no write may land.
        for (int c = 0; c < 5; c++) begin
            @(negedge stage_clk);
            instr = rand_instr(); stage_ena = 1'b1; flush = 1'b0;
            pc = $urandom; pc_next = pc + 32'd4;
            wb_we = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            #1;
            chk_val("rst.stall", 32'(stall_req), 32'd0);
            cmp_ex("rst");
        end
        @(negedge stage_clk);
        wb_we = 1'b0;
        reset = 1'b1;

        // Every register reads back zero after reset (ADD x0, xr, xr).
        for (int r = 1; r < 32; r++) begin
            step({7'd0, 5'(r), 5'(r), 3'd0, 5'd0, 7'h33}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            chk_val("rst.rf_rs1", ex_rs1_data, 32'd0);
        end

        step(32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("addi.valid", 32'(ex_valid), 32'd1);
        chk_val("addi.imm", ex_imm, 32'hFFFF_FFFF);
        chk_val("addi.rd", 32'(ex_rd), 32'd1);
        chk_val("addi.we_alu", 32'({ex_reg_we, ex_alu_src_imm}), 32'd3);
        chk_val("addi.rs1", ex_rs1_data, 32'd0);

        step(32'h0001_0133, 1'b1, 1'b0, 1'b1, 5'd2, 32'h1234);
        chk_val("byp.rs1", ex_rs1_data, 32'h1234);
        step(32'h0001_0133, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("byp.array", ex_rs1_data, 32'h1234);
        step(32'h0000_01B3, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk_val("x0.byp", ex_rs1_data, 32'd0);
        step(32'h0000_01B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("x0.array", ex_rs1_data, 32'd0);

        step(32'h0000_A283, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("lw.mem_re", 32'(ex_mem_re), 32'd1);
        step(32'h0022_8333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("lu.stall", 32'(obs_stall), 32'd1);
        chk_val("lu.bubble", 32'(ex_valid), 32'd0);
        step(32'h0022_8333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("lu.nostall", 32'(obs_stall), 32'd0);
        chk_val("lu.add_valid", 32'(ex_valid), 32'd1);
        chk_val("lu.add_rd", 32'(ex_rd), 32'd6);

        step(32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("beq.imm", ex_imm, 32'hFFFF_FFF8);
        chk_val("beq.branch", 32'(ex_branch), 32'd1);
        chk_val("beq.reg_we", 32'(ex_reg_we), 32'd0);
        step(32'hFFF0_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("hold.branch", 32'(ex_branch), 32'd1);

        step(32'hFFF0_0093, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        chk_val("flush.valid", 32'(ex_valid), 32'd0);

        // Flush while a load-use stall is pending.
        step(32'h0000_A283, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(32'h0022_8333, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk_val("fls.stall", 32'(obs_stall), 32'd1);
        step(32'h0022_8333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("fls.after", 32'(obs_stall), 32'd0);

        step(32'h0000_007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("ill.flag", 32'(ex_illegal), 32'd1);
        chk_val("ill.valid", 32'(ex_valid), 32'd1);
        chk_val("ill.ctl", 32'({ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump, ex_alu_src_imm}), 32'd0);

        step(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk_val("zero.valid", 32'(ex_valid), 32'd0);
        chk_val("zero.illegal", 32'(ex_illegal), 32'd0);

        rand_run(1500);

        // Asynchronous reset mid-run, with a write pending on the next edge.
        @(negedge stage_clk);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5_A5A5;
        #2 reset = 1'b0;
        #1;
        m_ex = '0;
        for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
        cmp_ex("arst");
        chk_val("arst.stall", 32'(stall_req), 32'd0);
        @(posedge stage_clk);
        #1 cmp_ex("arst_edge");
        @(negedge stage_clk);
        wb_we = 1'b0;
        reset = 1'b1;

        rand_run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
